// File: rtl/fp16_fix_conv_sched.sv
// Round-robin scheduler sharing one float-to-fix converter across NUM_REQ requesters, two-stage pipeline.
// Optional macro FP16_FIX_SCHED_SPECIAL_EN: all-ones exponent operands yield rsp_err_o=1 and zero data.
module fp16_fix_conv_sched #(
    parameter int NUM_REQ        = 4,
    parameter int FLOAT_OP_WIDTH = 16,
    parameter int EXP_MSB_POS    = 14,
    parameter int EXP_LSB_POS    = 10,
    parameter int FIXED_OP_WIDTH = 40
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*FLOAT_OP_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [FLOAT_OP_WIDTH-1:0]         conv_operand_o,
    input  logic [FIXED_OP_WIDTH-1:0]         conv_result_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [FIXED_OP_WIDTH-1:0]         rsp_data_o,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id_o,
    output logic                              rsp_err_o,
    output logic [15:0]                       conv_count_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [FLOAT_OP_WIDTH-1:0] req_data_arr [NUM_REQ];

    logic                      s1_valid_reg;
    logic [FLOAT_OP_WIDTH-1:0] s1_operand_reg;
    logic [ID_W-1:0]           s1_id_reg;

    logic                      s2_valid_reg;
    logic [FIXED_OP_WIDTH-1:0] s2_result_reg;
    logic [ID_W-1:0]           s2_id_reg;
    logic                      s2_err_reg;

    logic [ID_W-1:0]           last_grant_reg;
    logic [15:0]               conv_count_reg;

    logic [NUM_REQ-1:0]        prio_mask;
    logic [NUM_REQ-1:0]        masked_req;
    logic [NUM_REQ-1:0]        pick_vec;
    logic [ID_W-1:0]           grant_idx;
    logic                      grant_any;

    logic                      s2_adv;
    logic                      s1_adv;
    logic                      s1_free;
    logic                      take;
    logic                      special;
    logic [FIXED_OP_WIDTH-1:0] s2_result_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data_i[gi*FLOAT_OP_WIDTH +: FLOAT_OP_WIDTH];
            // Requesters strictly above the last winner get first chance.
            assign prio_mask[gi]    = (ID_W'(gi) > last_grant_reg);
        end
    endgenerate

    assign masked_req = req_valid_i & prio_mask;
    assign pick_vec   = (|masked_req) ? masked_req : req_valid_i;
    assign grant_any  = |req_valid_i;

    // Lowest set bit of pick_vec wins.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign s2_adv  = !s2_valid_reg || rsp_ready_i;
    assign s1_adv  = s1_valid_reg && s2_adv;
    assign s1_free = !s1_valid_reg || s1_adv;
    // rst_ni gates the grant so no requester sees ready while reset is held.
    assign take    = grant_any && s1_free && rst_ni;

    assign req_ready_o = take ? (NUM_REQ'(1) << grant_idx) : '0;

`ifdef FP16_FIX_SCHED_SPECIAL_EN
    assign special = &s1_operand_reg[EXP_MSB_POS:EXP_LSB_POS];
`else
    assign special = 1'b0;
`endif

    assign s2_result_next = special ? '0 : conv_result_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg   <= 1'b0;
            s1_operand_reg <= '0;
            s1_id_reg      <= '0;
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= '0;
            s2_id_reg      <= '0;
            s2_err_reg     <= 1'b0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            conv_count_reg <= '0;
        end else begin
            if (take) begin
                s1_valid_reg   <= 1'b1;
                s1_operand_reg <= req_data_arr[grant_idx];
                s1_id_reg      <= grant_idx;
                last_grant_reg <= grant_idx;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid_reg  <= 1'b1;
                s2_result_reg <= s2_result_next;
                s2_id_reg     <= s1_id_reg;
                s2_err_reg    <= special;
            end else if (s2_adv) begin
                s2_valid_reg <= 1'b0;
            end

            if (s2_valid_reg && rsp_ready_i) begin
                conv_count_reg <= conv_count_reg + 16'd1;
            end
        end
    end

    assign conv_operand_o = s1_valid_reg ? s1_operand_reg : '0;
    assign rsp_valid_o    = s2_valid_reg;
    assign rsp_data_o     = s2_result_reg;
    assign rsp_id_o       = s2_id_reg;
    assign rsp_err_o      = s2_err_reg;
    assign conv_count_o   = conv_count_reg;

endmodule

// File: tb/tb_fp16_fix_conv_sched.sv
// Scoreboard bench for fp16_fix_conv_sched: round-robin reference model plus in-order response queue.
module tb_fp16_fix_conv_sched;

    localparam int N   = 4;
    localparam int FW  = 16;
    localparam int XW  = 40;
    localparam int IDW = 2;

    typedef struct {
        logic [XW-1:0] data;
        int            id;
        logic          err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      drv_valid;
    logic [FW-1:0]     drv_data [N];
    logic [N*FW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [FW-1:0]     conv_operand;
    logic [XW-1:0]     conv_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XW-1:0]     rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic [15:0]       conv_count;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_data[gi*FW +: FW] = drv_data[gi];
    end

    // Converter model: zero extension of the operand.
    assign conv_result = {{(XW-FW){1'b0}}, conv_operand};

    fp16_fix_conv_sched #(
        .NUM_REQ(N), .FLOAT_OP_WIDTH(FW), .EXP_MSB_POS(14), .EXP_LSB_POS(10), .FIXED_OP_WIDTH(XW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(drv_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .conv_operand_o(conv_operand), .conv_result_i(conv_result),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_id_o(rsp_id), .rsp_err_o(rsp_err), .conv_count_o(conv_count)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         exp_q[$];
    int           acc_log[$];
    int           rsp_log[$];
    int           last_grant_m = N - 1;
    int           inflight = 0;
    int           hs_total = 0;
    logic [N-1:0] acc_vec = '0;
    int           gen_mode = 0;
    bit           verbose = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t ref_conv(input logic [FW-1:0] op, input int id);
        exp_t e;
        e.id = id;
`ifdef FP16_FIX_SCHED_SPECIAL_EN
        if (op[14:10] == 5'h1F) begin
            e.data = '0;
            e.err  = 1'b1;
        end else
`endif
        begin
            e.data = XW'(op);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [FW-1:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(7, 0) == 0) v[14:10] = 5'h1F;
        return v[FW-1:0];
    endfunction

    // Monitor: everything seen at the negedge is what the next rising edge commits.
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_ready;
        int g;
        if (!rst_n) begin
            check("ready_in_reset", req_ready, 0);
            check("rsp_valid_in_reset", rsp_valid, 0);
            check("count_in_reset", conv_count, 0);
            exp_q.delete();
            inflight     = 0;
            last_grant_m = N - 1;
            hs_total     = 0;
            acc_vec      = '0;
        end else begin
            g = rr_pick(drv_valid, last_grant_m);
            exp_ready = '0;
            if (g >= 0 && (inflight < 2 || rsp_ready)) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: actual id %0d data %0h, required no response", rsp_id, rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_id", rsp_id, exp_q[0].id);
                    check("rsp_err", rsp_err, exp_q[0].err);
                    if (rsp_ready) begin
                        check("conv_count", conv_count, hs_total & 16'hFFFF);
                        if (verbose)
                            $display("rsp id=%0d data=%0h err=%0b count=%0d", rsp_id, rsp_data, rsp_err, conv_count);
                        rsp_log.push_back(exp_q[0].id);
                        void'(exp_q.pop_front());
                        inflight--;
                        hs_total++;
                    end
                end
            end

            acc_vec = exp_ready;
            if (g >= 0 && exp_ready != 0) begin
                exp_q.push_back(ref_conv(drv_data[g], g));
                acc_log.push_back(g);
                last_grant_m = g;
                inflight++;
            end
        end
    end

    // mode 0: accepted requesters drop; 1: accepted requesters re-raise with new data;
    // 2: random valids and random rsp_ready.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gen_mode == 1) begin
                if (acc_vec[i]) drv_data[i] = rand_op();
            end else if (gen_mode == 2) begin
                if (acc_vec[i] || !drv_valid[i]) begin
                    drv_valid[i] = ($urandom_range(1, 0) == 1);
                    drv_data[i]  = rand_op();
                end
            end else if (acc_vec[i]) begin
                drv_valid[i] = 1'b0;
            end
        end
        if (gen_mode == 2) rsp_ready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic wait_acc(input int id);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (acc_vec[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        drv_valid = '0;
        gen_mode  = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drv_valid = '0;
        for (int i = 0; i < N; i++) drv_data[i] = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2
        drv_data[2] = 16'h3C00;
        drv_valid   = 4'b0100;
        wait_acc(2);
        step();
        check("single_latency_valid", rsp_valid, 1);
        check("single_id", rsp_id, 2);
        check("single_data", rsp_data, 40'h3C00);
        step();
        check("single_count", conv_count, 1);

        // Fairness from reset
        do_reset();
        acc_log.delete();
        for (int i = 0; i < N; i++) drv_data[i] = rand_op();
        drv_valid = 4'hF;
        gen_mode  = 1;
        repeat (8) step();
        check("fair_accepts", acc_log.size(), 8);
        for (int k = 0; k < 8 && k < acc_log.size(); k++) check("fair_order", acc_log[k], k % 4);

        // Drain, then backpressure with requesters 0 and 1
        gen_mode = 0;
        repeat (8) step();
        rsp_ready = 1'b0;
        acc_log.delete();
        rsp_log.delete();
        drv_data[0] = rand_op();
        drv_data[1] = rand_op();
        drv_valid   = 4'b0011;
        gen_mode    = 1;
        repeat (5) step();
        check("bp_accepts", acc_log.size(), 2);
        check("bp_ready_low", req_ready, 0);
        gen_mode  = 0;
        rsp_ready = 1'b1;
        repeat (8) step();
        check("bp_delivered", rsp_log.size() >= 2, 1);
        if (rsp_log.size() >= 2) begin
            check("bp_order0", rsp_log[0], 0);
            check("bp_order1", rsp_log[1], 1);
        end

        // Special operand
        drv_valid   = '0;
        drv_data[3] = 16'h7C00;
        drv_valid   = 4'b1000;
        wait_acc(3);
        step();
        check("special_valid", rsp_valid, 1);
`ifdef FP16_FIX_SCHED_SPECIAL_EN
        check("special_err", rsp_err, 1);
        check("special_data", rsp_data, 0);
`else
        check("special_err", rsp_err, 0);
        check("special_data", rsp_data, 40'h7C00);
`endif
        step();

        // Random traffic with random backpressure
        gen_mode = 2;
        repeat (3000) step();
        gen_mode  = 0;
        rsp_ready = 1'b1;
        repeat (20) step();
        check("random_drained", exp_q.size(), 0);

        // Counter wrap after 65536 responses
        do_reset();
        verbose = 1'b0;
        for (int i = 0; i < N; i++) drv_data[i] = rand_op();
        drv_valid = 4'hF;
        gen_mode  = 1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            step();
            if (hs_total >= 65536) break;
        end
        verbose = 1'b1;
        check("wrap_reached", hs_total, 65536);
        check("wrap_count", conv_count, 0);

        // Reset with both stages full
        rsp_ready = 1'b0;
        repeat (4) step();
        check("full_before_reset", rsp_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 0);
        check("async_ready", req_ready, 0);
        check("async_count", conv_count, 0);
        drv_valid = '0;
        gen_mode  = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        rsp_log.delete();
        repeat (10) step();
        check("no_rsp_after_reset", rsp_log.size(), 0);
        check("count_after_reset", conv_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
